gpio_wb_arbiter: RTL

Two-master round-robin Wishbone arbiter that shares the single Wishbone slave port of the FPGA GPIO register bank. Master 0 is the AHB-to-FPGA bridge; master 1 is a local FPGA requester, such as a pattern or PWM engine.
The block holds the grant for the whole CYC span so that read-modify-write sequences stay atomic. A watchdog terminates any slave access that never acknowledges, and reports it to the owning master as an error.

---
 rtl/gpio_wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gpio_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the GPIO register bank slave port.
// Grant is held for the whole CYC span; a watchdog turns a silent slave into an ERR pulse.
//
// state | meaning
// IDLE  | no owner, slave port quiet, arbitration on requests
// OWN0  | master 0 owns the slave until it drops CYC or times out
// OWN1  | master 1 owns the slave until it drops CYC or times out
module gpio_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADR_W          = 17
) (
    input  logic             WBs_CLK_i,
    input  logic             WBs_RST_i,
    input  logic [ADR_W-1:0] M0_ADR_i,
    input  logic             M0_CYC_i,
    input  logic             M0_STB_i,
    input  logic             M0_WE_i,
    input  logic [3:0]       M0_BYTE_STB_i,
    input  logic [31:0]      M0_DAT_i,
    output logic [31:0]      M0_DAT_o,
    output logic             M0_ACK_o,
    output logic             M0_ERR_o,
    input  logic [ADR_W-1:0] M1_ADR_i,
    input  logic             M1_CYC_i,
    input  logic             M1_STB_i,
    input  logic             M1_WE_i,
    input  logic [3:0]       M1_BYTE_STB_i,
    input  logic [31:0]      M1_DAT_i,
    output logic [31:0]      M1_DAT_o,
    output logic             M1_ACK_o,
    output logic             M1_ERR_o,
    output logic [ADR_W-1:0] S_ADR_o,
    output logic             S_CYC_o,
    output logic             S_STB_o,
    output logic             S_WE_o,
    output logic [3:0]       S_BYTE_STB_o,
    output logic [31:0]      S_DAT_o,
    input  logic [31:0]      S_DAT_i,
    input  logic             S_ACK_i,
    output logic [1:0]       GRANT_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             req0, req1;
    logic             own0, own1;
    logic             m_cyc, m_stb;
    logic             tmo;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    assign req0 = M0_CYC_i && M0_STB_i;
    assign req1 = M1_CYC_i && M1_STB_i;
    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    assign m_cyc = own1 ? M1_CYC_i : M0_CYC_i;
    assign m_stb = own1 ? M1_STB_i : M0_STB_i;

    // A same-cycle ACK beats the timeout match.
    assign tmo = (TIMEOUT_CYCLES != 0) && (own0 || own1) &&
                 (cnt == CNT_W'(TIMEOUT_CYCLES)) && !S_ACK_i;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = '0;

        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant)) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (tmo || !m_cyc) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = own1;
                end else if (!S_ACK_i && m_stb && (TIMEOUT_CYCLES != 0)) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        S_ADR_o      = '0;
        S_CYC_o      = 1'b0;
        S_STB_o      = 1'b0;
        S_WE_o       = 1'b0;
        S_BYTE_STB_o = '0;
        S_DAT_o      = '0;
        M0_ACK_o     = 1'b0;
        M1_ACK_o     = 1'b0;
        M0_ERR_o     = 1'b0;
        M1_ERR_o     = 1'b0;

        if (own0) begin
            S_ADR_o      = M0_ADR_i;
            S_CYC_o      = M0_CYC_i && !tmo;
            S_STB_o      = M0_STB_i && !tmo;
            S_WE_o       = M0_WE_i;
            S_BYTE_STB_o = M0_BYTE_STB_i;
            S_DAT_o      = M0_DAT_i;
            M0_ACK_o     = S_ACK_i;
            M0_ERR_o     = tmo;
        end else if (own1) begin
            S_ADR_o      = M1_ADR_i;
            S_CYC_o      = M1_CYC_i && !tmo;
            S_STB_o      = M1_STB_i && !tmo;
            S_WE_o       = M1_WE_i;
            S_BYTE_STB_o = M1_BYTE_STB_i;
            S_DAT_o      = M1_DAT_i;
            M1_ACK_o     = S_ACK_i;
            M1_ERR_o     = tmo;
        end
    end

    assign M0_DAT_o = S_DAT_i;
    assign M1_DAT_o = S_DAT_i;
    assign GRANT_o  = {own1, own0};

endmodule
